rx_deframer: RTL and testbench

RX_DEFRAMER -- requirements
Module: rx_deframer

---
 rtl/rx_deframer.sv | 177 +++++++++++++++++
 tb/tb_rx_deframer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_deframer.sv
// Serial frame receiver: start bit, 8-bit header, DATA_W payload bits, stop bit.
// Optional even-parity bit after the payload when RX_PARITY_CHK_EN is defined.
module rx_deframer #(
  parameter int         DATA_W = 24,
  parameter logic [3:0] SYNC   = 4'hA
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        ch_id,
  output logic              rx_valid,
  output logic              frame_err,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       err_cnt,
  output logic              busy,
  output logic [2:0]        o_dbg_state
);

  localparam int CNT_W = $clog2((DATA_W > 8) ? DATA_W : 8) + 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
`ifdef RX_PARITY_CHK_EN
    ST_PAR  = 3'd3,
`endif
    ST_STOP = 3'd4,
    ST_HUNT = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [6:0]          r_hdr;
  logic [1:0]          r_ch_stage;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_ch;
  logic                r_rx_valid;
  logic                r_frame_err;
  logic [15:0]         r_pkt_cnt;
  logic [15:0]         r_err_cnt;
  logic [7:0]          w_hdr_word;
  logic                w_good;
  logic                w_err;
  logic                w_par_bad;

`ifdef RX_PARITY_CHK_EN
  logic                r_par;
  logic                r_par_err;
  assign w_par_bad = r_par_err;
`else
  assign w_par_bad = 1'b0;
`endif

  // The 8th header bit is checked as it arrives, so the header word includes rx.
  assign w_hdr_word = {r_hdr, rx};

  always_comb begin
    w_next = r_state;
    w_good = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      ST_IDLE: if (!rx) w_next = ST_HDR;
      ST_HDR: begin
        if (r_bit_cnt == CNT_W'(7)) begin
          if ((w_hdr_word[7:4] != SYNC) || (w_hdr_word[3:2] == 2'b11)) begin
            w_err  = 1'b1;
            w_next = ST_HUNT;
          end else begin
            w_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef RX_PARITY_CHK_EN
          w_next = ST_PAR;
`else
          w_next = ST_STOP;
`endif
        end
      end
`ifdef RX_PARITY_CHK_EN
      ST_PAR: w_next = ST_STOP;
`endif
      ST_STOP: begin
        if (rx && !w_par_bad) begin
          w_good = 1'b1;
          w_next = ST_IDLE;
        end else begin
          w_err  = 1'b1;
          w_next = ST_HUNT;
        end
      end
      ST_HUNT: if (rx) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_hdr      <= '0;
      r_ch_stage <= '0;
      r_shift    <= '0;
`ifdef RX_PARITY_CHK_EN
      r_par      <= 1'b0;
      r_par_err  <= 1'b0;
`endif
    end else begin
      if (w_next != r_state) r_bit_cnt <= '0;
      else if ((r_state == ST_HDR) || (r_state == ST_DATA)) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      case (r_state)
        ST_HDR: begin
          r_hdr <= w_hdr_word[6:0];
          if (r_bit_cnt == CNT_W'(7)) r_ch_stage <= w_hdr_word[3:2];
`ifdef RX_PARITY_CHK_EN
          r_par <= r_par ^ rx;
`endif
        end
        ST_DATA: begin
          r_shift <= {r_shift[DATA_W-2:0], rx};
`ifdef RX_PARITY_CHK_EN
          r_par <= r_par ^ rx;
`endif
        end
`ifdef RX_PARITY_CHK_EN
        ST_IDLE: begin
          r_par     <= 1'b0;
          r_par_err <= 1'b0;
        end
        ST_PAR: r_par_err <= r_par ^ rx;
`endif
        default: ;
      endcase
    end
  end

  // Outputs are registered: results appear the cycle after the deciding sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_ch        <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_rx_valid  <= w_good;
      r_frame_err <= w_err;
      if (w_good) begin
        r_data <= r_shift;
        r_ch   <= r_ch_stage;
        if (r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end
      if (w_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign data_out    = r_data;
  assign ch_id       = r_ch;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign pkt_cnt     = r_pkt_cnt;
  assign err_cnt     = r_err_cnt;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rx_deframer.sv
// Bench for rx_deframer: frame-level reference model with an event queue keyed
// by the clock edge at which each result must appear, plus directed literal checks.
module tb_rx_deframer;

  localparam int         DATA_W = 24;
  localparam logic [3:0] SYNC   = 4'hA;
`ifdef RX_PARITY_CHK_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_LEN = 1 + 8 + DATA_W + PAR_BITS + 1;
  localparam int EW = 32 + 2 + 2 + DATA_W;
  localparam logic [1:0] K_GOOD = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx = 1'b1;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        ch_id;
  logic              rx_valid;
  logic              frame_err;
  logic [15:0]       pkt_cnt;
  logic [15:0]       err_cnt;
  logic              busy;
  logic [2:0]        dbg_state;

  rx_deframer #(.DATA_W(DATA_W), .SYNC(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .data_out(data_out), .ch_id(ch_id), .rx_valid(rx_valid), .frame_err(frame_err),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .busy(busy), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned edge_cnt = 0;
  int unsigned bit_edge = 0;
  logic [EW-1:0]     exp_q[$];
  int unsigned       valid_edges[$];
  logic [DATA_W-1:0] m_data = '0;
  logic [1:0]        m_ch = '0;
  logic [15:0]       m_pkt = '0;
  logic [15:0]       m_err = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Scoreboard: each clock edge, retire the event due now and compare all outputs.
  task automatic cycle_check();
    logic          ev_v;
    logic          ev_e;
    logic [EW-1:0] e;
    if (!rst_n) begin
      m_data = '0; m_ch = '0; m_pkt = '0; m_err = '0;
      exp_q.delete();
      check("rst_data_out", data_out, 0);
      check("rst_ch_id", ch_id, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_pkt_cnt", pkt_cnt, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_busy", busy, 0);
    end else begin
      ev_v = 1'b0;
      ev_e = 1'b0;
      while (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] < edge_cnt) begin
        e = exp_q.pop_front();
        check("event_missed", edge_cnt, e[EW-1 -: 32]);
      end
      if (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] == edge_cnt) begin
        e = exp_q.pop_front();
        if (e[EW-33 -: 2] == K_GOOD) begin
          ev_v   = 1'b1;
          m_data = e[DATA_W-1:0];
          m_ch   = e[DATA_W+1 -: 2];
          if (m_pkt != 16'hFFFF) m_pkt++;
        end else begin
          ev_e = 1'b1;
          if (m_err != 16'hFFFF) m_err++;
        end
      end
      check("rx_valid", rx_valid, ev_v);
      check("frame_err", frame_err, ev_e);
      check("data_out", data_out, m_data);
      check("ch_id", ch_id, m_ch);
      check("pkt_cnt", pkt_cnt, m_pkt);
      check("err_cnt", err_cnt, m_err);
      if (rx_valid) valid_edges.push_back(edge_cnt);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      #1;
      cycle_check();
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    bit_edge = edge_cnt + 1;
  endtask

  task automatic push_ev(input logic [1:0] kind, input logic [1:0] ch, input logic [DATA_W-1:0] d);
    exp_q.push_back({bit_edge, kind, ch, d});
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [DATA_W-1:0] pl,
                            input logic par_flip, input logic stop_b, output logic was_err);
    logic par_bad;
    par_bad = 1'b0;
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(hdr[i]);
    if ((hdr[7:4] != SYNC) || (hdr[3:2] == 2'b11)) begin
      push_ev(K_ERR, 2'd0, '0);
      was_err = 1'b1;
      return;
    end
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(pl[i]);
`ifdef RX_PARITY_CHK_EN
    send_bit((^{hdr, pl}) ^ par_flip);
    par_bad = par_flip;
`endif
    send_bit(stop_b);
    was_err = !(stop_b && !par_bad);
    if (was_err) push_ev(K_ERR, 2'd0, '0);
    else         push_ev(K_GOOD, hdr[3:2], pl);
  endtask

  task automatic recover(input int lows);
    repeat (lows) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  initial begin
    logic              er;
    logic [7:0]        hdr;
    logic [DATA_W-1:0] pl;
    logic [3:0]        nib;
    int                kind;
    int                nv;

    repeat (3) @(negedge clk);
    check("init_data_out", data_out, 0);
    check("init_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) send_bit(1'b1);

    // Channel 1 good frame, then pin the model with literals.
    send_frame(8'hA4, 24'hC35A01, 1'b0, 1'b1, er);
    send_bit(1'b1);
    check("lit_data_c35a01", data_out, 24'hC35A01);
    check("lit_ch_1", ch_id, 2'd1);
    check("lit_pkt_1", pkt_cnt, 16'd1);
    check("lit_latency", valid_edges[valid_edges.size()-1], bit_edge - 1);
    check("lit_idle_busy", busy, 0);

    // Bad sync: error right after the 8th header bit, line held low, then good frame.
    send_frame(8'h54, 24'h0, 1'b0, 1'b1, er);
    recover(5);
    check("lit_err_1", err_cnt, 16'd1);
    check("lit_hold_data", data_out, 24'hC35A01);
    send_frame(8'hA0, 24'hFFFFFF, 1'b0, 1'b1, er);
    send_bit(1'b1);
    check("lit_data_ffffff", data_out, 24'hFFFFFF);
    check("lit_pkt_2", pkt_cnt, 16'd2);

    // Channel 2 frame with bad stop bit, stuck low for 10 cycles.
    send_frame(8'hA8, 24'h5A5A5A, 1'b0, 1'b0, er);
    recover(10);
    check("lit_err_2", err_cnt, 16'd2);
    check("lit_pkt_still_2", pkt_cnt, 16'd2);
    check("lit_ch_still_0", ch_id, 2'd0);

    // Two frames back to back with no idle gap.
    send_frame(8'hA3, 24'h000000, 1'b0, 1'b1, er);
    send_frame(8'hA8, 24'h800001, 1'b0, 1'b1, er);
    send_bit(1'b1);
    nv = valid_edges.size();
`ifdef RX_PARITY_CHK_EN
    check("lit_b2b_gap", valid_edges[nv-1] - valid_edges[nv-2], FRAME_LEN);
`else
    check("lit_b2b_gap", valid_edges[nv-1] - valid_edges[nv-2], 34);
`endif
    check("lit_pkt_4", pkt_cnt, 16'd4);
    check("lit_data_800001", data_out, 24'h800001);
    check("lit_ch_2", ch_id, 2'd2);

    // Reset pulsed in the middle of the payload.
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(hdr_const(i));
    for (int i = 0; i < 10; i++) send_bit(i[0]);
    @(posedge clk);
    #2;
    check("lit_busy_mid", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("lit_rst_data", data_out, 0);
    check("lit_rst_pkt", pkt_cnt, 0);
    check("lit_rst_err", err_cnt, 0);
    check("lit_rst_busy", busy, 0);
    @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    send_bit(1'b1);
    send_frame(8'hA8, 24'h123456, 1'b0, 1'b1, er);
    send_bit(1'b1);
    check("lit_post_rst_data", data_out, 24'h123456);
    check("lit_post_rst_ch", ch_id, 2'd2);
    check("lit_post_rst_pkt", pkt_cnt, 16'd1);
    check("lit_post_rst_err", err_cnt, 16'd0);

`ifdef RX_PARITY_CHK_EN
    send_frame(8'hA4, 24'h000001, 1'b1, 1'b1, er);
    recover(0);
    check("lit_par_err", err_cnt, 16'd1);
    send_frame(8'hA4, 24'h000001, 1'b0, 1'b1, er);
    send_bit(1'b1);
    check("lit_par_ok_data", data_out, 24'h000001);
    check("lit_par_ok_pkt", pkt_cnt, 16'd2);
`endif

    // Randomized mix of good and faulty frames.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      pl   = DATA_W'($urandom);
      hdr  = {SYNC, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 3))};
      if (kind == 6) begin
        do nib = 4'($urandom_range(0, 15)); while (nib == SYNC);
        hdr[7:4] = nib;
      end else if (kind == 7) begin
        hdr[3:2] = 2'b11;
      end
      send_frame(hdr, pl, kind == 9, kind != 8, er);
      if (er) recover($urandom_range(0, 4));
      else repeat ($urandom_range(0, 2)) send_bit(1'b1);
    end

    repeat (3) send_bit(1'b1);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic hdr_const(input int i);
    logic [7:0] h;
    h = 8'hA4;
    return h[i];
  endfunction

endmodule
